// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bus between the ID/EX stage and the RV32M multiply/divide unit.
// Handshake: the unit takes start only while busy is low; done pulses for one cycle when result is updated.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      select;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, select, data1, data2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, select, data1, data2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide: radix-2 shift-add / restoring divide on magnitudes plus a sign-fix cycle.
// Define MULDIV_FAST_EN to finish divide-by-zero, signed overflow and zero-operand multiplies straight from IDLE.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    ex_muldiv_unit_if.slave      bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   mag_a_q, mag_b_q;
    logic              neg_res_q, neg_rem_q, b_zero_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   result_q;

    logic              accept, a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_result;

    assign accept = bus.start && !bus.flush && (state_q == S_IDLE || state_q == S_DONE);

    // MULHSU treats rs2 as unsigned; MULHU/DIVU/REMU treat both as unsigned.
    always_comb begin
        a_signed = bus.select[2] ? !bus.select[0] : (bus.select != 3'b011);
        b_signed = bus.select[2] ? !bus.select[0] : !bus.select[1];
        neg_a    = a_signed && bus.data1[XLEN-1];
        neg_b    = b_signed && bus.data2[XLEN-1];
        mag_a    = neg_a ? -bus.data1 : bus.data1;
        mag_b    = neg_b ? -bus.data2 : bus.data2;
    end

`ifdef MULDIV_FAST_EN
    logic            fast_hit;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        fast_hit    = 1'b0;
        fast_result = '0;
        if (bus.select[2] && bus.data2 == '0) begin
            fast_hit    = 1'b1;
            fast_result = bus.select[1] ? bus.data1 : '1;
        end else if (bus.select[2] && !bus.select[0] &&
                     bus.data1 == {1'b1, {(XLEN-1){1'b0}}} && bus.data2 == '1) begin
            fast_hit    = 1'b1;
            fast_result = bus.select[1] ? '0 : bus.data1;
        end else if (!bus.select[2] && (bus.data1 == '0 || bus.data2 == '0)) begin
            fast_hit    = 1'b1;
            fast_result = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
`ifdef MULDIV_FAST_EN
                    state_d = fast_hit ? S_DONE : S_CALC;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (bus.flush)                         state_d = S_IDLE;
                else if (cnt_q == CNT_W'(XLEN - 1))    state_d = S_FIX;
            end
            S_FIX:   state_d = bus.flush ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q == S_CALC) || (state_q == S_FIX);
        bus.done  = (state_q == S_DONE);
        dbg_state = state_q;
    end

    // One radix-2 step: multiplier shifts out of acc[0]; divide shifts the dividend into the remainder half.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, mag_b_q};
        prod_fix = neg_res_q ? -acc_q : acc_q;
        if (!op_q[2])
            fix_result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (op_q[1])
            fix_result = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        else if (b_zero_q)
            fix_result = '1;
        else
            fix_result = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        op_q      <= bus.select;
                        mag_a_q   <= mag_a;
                        mag_b_q   <= mag_b;
                        neg_res_q <= neg_a ^ neg_b;
                        neg_rem_q <= neg_a;
                        b_zero_q  <= (bus.data2 == '0);
                        acc_q     <= bus.select[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
`ifdef MULDIV_FAST_EN
                        if (fast_hit) result_q <= fast_result;
`endif
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!op_q[2])
                        acc_q <= {mul_sum, acc_q[XLEN-1:1]};
                    else if (!div_diff[XLEN+1])
                        acc_q <= {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_q <= {acc_q[2*XLEN-2:0], 1'b0};
                end
                S_FIX: begin
                    if (!bus.flush) result_q <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table, random ops against a plain-arithmetic model,
// and hand sequences for back-to-back issue, START while busy, FLUSH and RESET aborts.
module tb_ex_muldiv_unit;
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    int          n_vec;
    int          n_bad;
    logic [31:0] last_exp;
    logic [31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (sel)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_EN
        if (sel[2] && b == 0) return 1'b1;
        if ((sel == 3'd4 || sel == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        if (!sel[2] && (a == 0 || b == 0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive one START at a negedge; returns at the negedge after the sampling edge with inputs scrambled.
    task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.select = sel;
        bus.data1  = a;
        bus.data2  = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.select = 3'($urandom_range(0, 7));
        bus.data1  = $urandom;
        bus.data2  = $urandom;
    endtask

    task automatic wait_done(input string name, input int exp_busy, input bit poke);
        int busy_cnt;
        int cycles;
        logic [31:0] exp;
        busy_cnt = 0;
        cycles   = 0;
        exp      = exp_q.pop_front();
        while (!bus.done && cycles < 100) begin
            if (bus.busy) busy_cnt++;
            bus.start = poke && (busy_cnt == 5);
            cycles++;
            @(negedge clk);
            bus.start = 1'b0;
        end
        check({name, " done"}, 32'(bus.done), 32'd1);
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({name, " result"}, bus.result, exp);
        last_exp = exp;
    endtask

    task automatic run_op(input string name, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit poke);
        exp_q.push_back(exp);
        issue(sel, a, b);
        wait_done(name, is_fast(sel, a, b) ? 0 : 33, poke);
        @(negedge clk);
        check({name, " done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    task automatic watch_no_done(input string name, input int n);
        logic saw;
        saw = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw = 1'b1;
        end
        check({name, " quiet"}, 32'(saw), 32'd0);
    endtask

    initial begin
        vec_t vt[14];
        logic [2:0]  rs;
        logic [31:0] ra, rb;

        n_vec      = 0;
        n_bad      = 0;
        last_exp   = 32'h0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.select = 3'd0;
        bus.data1  = 32'h0;
        bus.data2  = 32'h0;

        vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vt[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vt[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vt[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vt[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vt[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vt[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vt[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
        vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vt[12] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF};
        vt[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);

        // Directed table
        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vt[i].sel, vt[i].a, vt[i].b, vt[i].exp, 1'b0);

        // START during the DONE cycle is taken with no idle bubble
        exp_q.push_back(32'hFFFF_FFFD);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_done("b2b first", 33, 1'b0);
        exp_q.push_back(32'd14);
        issue(3'd5, 32'd100, 32'd7);
        wait_done("b2b second", 33, 1'b0);
        @(negedge clk);

        // START while busy is ignored
        run_op("start_while_busy", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);

        // FLUSH together with START in IDLE does not launch
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.select = 3'd5;
        bus.data1 = 32'd100;
        bus.data2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        watch_no_done("flush_with_start", 40);
        check("flush_with_start result", bus.result, last_exp);

        // FLUSH on the 10th busy cycle
        issue(3'd5, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("flush pre busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush done", 32'(bus.done), 32'd0);
        check("flush result", bus.result, last_exp);
        watch_no_done("flush", 40);

        // RESET on the 10th busy cycle
        issue(3'd5, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_exp = 32'h0;
        check("abort_reset busy", 32'(bus.busy), 32'd0);
        check("abort_reset result", bus.result, 32'd0);
        watch_no_done("abort_reset", 40);

        // Random ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rs = 3'($urandom_range(0, 7));
            ra = rand_operand();
            rb = rand_operand();
            run_op($sformatf("rand%0d sel=%0d a=%h b=%h", i, rs, ra, rb), rs, ra, rb,
                   ref_model(rs, ra, rb), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
